// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port around dmem_arbiter.
// master: requesters plus memory model side; slave: the arbiter.
`ifndef MEM_SPACE
`define MEM_SPACE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

interface dmem_arbiter_if #(
  parameter int ADDR_W = `MEM_SPACE,
  parameter int DATA_W = `DSIZE
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported synchronous-read data memory.
// Port A (CPU MEM stage) has fixed priority; port B (DMA/debug loader) is
// forced through after STARVE_MAX consecutive denials.
//
// Read-owner tag (rd_owner):
//   state    | meaning
//   OWN_NONE | no read issued last cycle, no rvalid this cycle
//   OWN_A    | port A read granted last cycle, mem_rdata belongs to A
//   OWN_B    | port B read granted last cycle, mem_rdata belongs to B
`ifndef MEM_SPACE
`define MEM_SPACE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

module dmem_arbiter #(
  parameter int ADDR_W     = `MEM_SPACE,
  parameter int DATA_W     = `DSIZE,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;

  owner_e            rd_owner_q, rd_owner_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic              force_b;
  logic              a_gnt, b_gnt;
  logic              a_rvalid, b_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  // Grant decision: forced B slot first, then A priority, then B; nothing during reset
  always_comb begin
    force_b = (starve_cnt_q == STARVE_LIM) && bus.b_req;
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    if (!rst) begin
      if (force_b) begin
        b_gnt = 1'b1;
      end else if (bus.a_req) begin
        a_gnt = 1'b1;
      end else if (bus.b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  // Memory mux; with no winner the address parks on the last granted one
  always_comb begin
    mem_addr    = addr_hold_q;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    addr_hold_d = addr_hold_q;
    if (a_gnt) begin
      mem_addr    = bus.a_addr;
      mem_wdata   = bus.a_wdata;
      mem_we      = bus.a_we;
      addr_hold_d = bus.a_addr;
    end else if (b_gnt) begin
      mem_addr    = bus.b_addr;
      mem_wdata   = bus.b_wdata;
      mem_we      = bus.b_we;
      addr_hold_d = bus.b_addr;
    end
  end

  // Starvation counter: counts consecutive B denials, saturating at the limit
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (b_gnt || !bus.b_req) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Next read owner: tag whichever port won a read this cycle
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (a_gnt && !bus.a_we) begin
      rd_owner_d = OWN_A;
    end else if (b_gnt && !bus.b_we) begin
      rd_owner_d = OWN_B;
    end
  end

  // Read return: owner sees memory data this cycle, the other port keeps its last value.
  // Reset suppresses a pending return so no rvalid leaks across it.
  always_comb begin
    a_rvalid  = (rd_owner_q == OWN_A) && !rst;
    b_rvalid  = (rd_owner_q == OWN_B) && !rst;
    a_rdata_d = a_rvalid ? bus.mem_rdata : a_rdata_q;
    b_rdata_d = b_rvalid ? bus.mem_rdata : b_rdata_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner_q   <= OWN_NONE;
      starve_cnt_q <= 4'd0;
      addr_hold_q  <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
      addr_hold_q  <= addr_hold_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  assign bus.a_gnt     = a_gnt;
  assign bus.b_gnt     = b_gnt;
  assign bus.a_rvalid  = a_rvalid;
  assign bus.b_rvalid  = b_rvalid;
  assign bus.a_rdata   = a_rdata_d;
  assign bus.b_rdata   = b_rdata_d;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_we    = mem_we;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-ported, synchronous-read data memory between the CPU MEM stage (port A) and the DMA/debug loader (port B). Each cycle it selects at most one requester, drives the memory address/data/write-enable combinationally from the winner, and returns read data with a one-cycle `rvalid` strobe to the port that issued the read. Port A has fixed priority. A starvation counter guarantees port B a slot after a bounded number of denials. The block sits between the pipeline/loader and the data memory.

## Interface
- `ADDR_W`, default `` `MEM_SPACE ``: address width.
- `DATA_W`, default `` `DSIZE ``: data width.
- `STARVE_MAX`, default 4: consecutive B denials before B is forced (range 1–15).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `a_req`  in  1  port A access request, level.
- `a_we`  in  1  port A write (1) / read (0).
- `a_addr`  in  ADDR_W  port A address.
- `a_wdata`  in  DATA_W  port A write data.
- `a_gnt`  out  1  port A granted this cycle (combinational).
- `a_rvalid`  out  1  port A read data valid (registered).
- `a_rdata`  out  DATA_W  port A read data.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as the port A signals, for port B.
- `mem_addr`  out  ADDR_W  to memory address.
- `mem_wdata`  out  DATA_W  to memory data input.
- `mem_we`  out  1  to memory write enable.
- `mem_rdata`  in  DATA_W  from memory data output; registered, valid the cycle after the address edge.

## Operation
- Grant rule, combinational from current inputs and state:
  - `force_b` = (`starve_cnt` == STARVE_MAX) and `b_req`.
  - If `force_b`: `b_gnt` = 1.
  - Else if `a_req`: `a_gnt` = 1.
  - Else if `b_req`: `b_gnt` = 1.
  - At most one grant per cycle; never a grant without the matching req.
- Memory mux:
  - `mem_addr`/`mem_wdata`/`mem_we` come from the granted port.
  - With no grant: `mem_we` = 0, `mem_addr` holds the last granted address (no spurious writes).
- Starvation counter `starve_cnt` (4 bits):
  - Reset to 0 when `b_gnt` = 1 or `b_req` = 0.
  - Increments by 1 when `b_req` = 1 and `b_gnt` = 0.
  - Saturates at STARVE_MAX.
- A denied requester holds req/addr/we/wdata stable until granted. The requester drops or changes them only in the cycle after its gnt.
- Read return:
  - Registered tag `rd_owner` ∈ {NONE, A, B} is captured at each edge: A/B if that port was granted a read, else NONE.
  - In the following cycle, `x_rvalid` = 1 for the owner. `x_rdata` = `mem_rdata` for the owner, otherwise holds its last value.
- Write: the write completes at the grant edge. No rvalid is returned for writes.
- Back-to-back: a new grant is allowed every cycle. Read-after-write to the same address in the next cycle returns the new data, because the memory captures the write first.
- Reset (rst = 1 at an edge):
  - `starve_cnt` = 0, `rd_owner` = NONE.
  - `a_rdata` = `b_rdata` = 0, `mem_addr` hold register = 0.
  - While rst = 1: all gnt = 0, `mem_we` = 0.
  - A read granted in the cycle before reset asserts is dropped: no rvalid after reset.

## Timing
- Grant: same cycle as req (0-cycle arbitration).
- Read latency: grant in cycle N, rvalid and rdata in cycle N+1.
- Worst-case B wait with continuous A traffic: STARVE_MAX denied cycles, then granted on cycle STARVE_MAX+1.
- A waits at most 1 cycle (a single forced B slot).
- Reset outputs: `a_gnt` = `b_gnt` = 0, `a_rvalid` = `b_rvalid` = 0, `a_rdata` = `b_rdata` = 0, `mem_we` = 0, `mem_addr` = 0.

## Test plan
- A read only: memory preloaded with 0x1234 at address 0x05; `a_req` = 1, `a_we` = 0, `a_addr` = 0x05 for 1 cycle -> `a_gnt` = 1 that cycle; next cycle `a_rvalid` = 1, `a_rdata` = 0x1234; `b_rvalid` stays 0.
- Contention, STARVE_MAX = 4: `a_req` and `b_req` held high continuously -> `a_gnt` in cycles 1–4, `b_gnt` in cycle 5, A in cycles 6–9, B in cycle 10; never both grants high.
- Cross-port coherence: B writes 0xBEEF to 0x10 (`b_we` = 1), then A reads 0x10 in the next cycle -> `a_rdata` = 0xBEEF one cycle after `a_gnt`; `mem_we` is high for exactly 1 cycle.
- Idle: no requests for 10 cycles -> `mem_we` = 0 throughout, `mem_addr` holds the last granted address, no rvalid pulses.
- Reset mid-operation: A read granted in cycle N, rst = 1 in cycle N+1 -> `a_rvalid` = 0, `a_rdata` = 0 after the edge, `starve_cnt` = 0. After rst is deasserted, a B-only request is granted immediately.
- Request removal: B denied for 3 cycles, then `b_req` drops for 1 cycle, then reasserts with A busy -> counter restarts from 0, and B is forced only after 4 further denials.
